// File: rtl/shift_issue_queue.sv
// rtl/shift_issue_queue.sv - 2-entry request FIFO feeding a registered rotate/logical-right-shift unit
module shift_issue_queue #(
    parameter int OPERAND_WIDTH = 16,
    parameter int SHAMT_WIDTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPERAND_WIDTH-1:0] in_data,
    input  logic [SHAMT_WIDTH-1:0]   in_shamt,
    input  logic                     in_oper,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPERAND_WIDTH-1:0] out_data,
    output logic [1:0]               count
);

    // One queued request: operand, amount and operation packed together.
    localparam int ENTRY_WIDTH = OPERAND_WIDTH + SHAMT_WIDTH + 1;

    logic [ENTRY_WIDTH-1:0]   mem_q [2];
    logic [ENTRY_WIDTH-1:0]   mem_d [2];
    logic                     wr_ptr_q, wr_ptr_d;
    logic                     rd_ptr_q, rd_ptr_d;
    logic [1:0]               count_q, count_d;
    logic                     out_valid_q, out_valid_d;
    logic [OPERAND_WIDTH-1:0] out_data_q, out_data_d;
    // Held low through reset so in_ready is 0 while rst=1 and rises on the first edge after release.
    logic                     rdy_en_q, rdy_en_d;

    logic                     push;
    logic                     pop;
    logic [ENTRY_WIDTH-1:0]   head;
    logic [OPERAND_WIDTH-1:0] head_result;

    // Rotate uses a doubled operand so bits shifted out at the bottom re-enter at the top.
    function automatic logic [OPERAND_WIDTH-1:0] shift_op(
        input logic [OPERAND_WIDTH-1:0] data,
        input logic [SHAMT_WIDTH-1:0]   shamt,
        input logic                     oper
    );
        logic [2*OPERAND_WIDTH-1:0] dbl;
        dbl = {data, data} >> shamt;
        if (oper) begin
            shift_op = data >> shamt;
        end else begin
            shift_op = dbl[OPERAND_WIDTH-1:0];
        end
    endfunction

    assign in_ready  = rdy_en_q && (count_q != 2'd2);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign count     = count_q;

    assign head        = mem_q[rd_ptr_q];
    assign head_result = shift_op(head[ENTRY_WIDTH-1 -: OPERAND_WIDTH],
                                  head[SHAMT_WIDTH:1], head[0]);

    // Next-state: FIFO push/pop, result register load/drain, ready enable.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        rdy_en_d    = 1'b1;

        push = in_valid && in_ready;
        pop  = (count_q != 2'd0) && (!out_valid_q || out_ready);

        if (push) begin
            mem_d[wr_ptr_q] = {in_data, in_shamt, in_oper};
            wr_ptr_d        = ~wr_ptr_q;
        end

        if (pop) begin
            rd_ptr_d    = ~rd_ptr_q;
            out_data_d  = head_result;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // State registers; reset discards every queued and registered request at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            rdy_en_q    <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            rdy_en_q    <= rdy_en_d;
        end
    end

endmodule

// File: tb/tb_shift_issue_queue.sv
// tb/tb_shift_issue_queue.sv - directed self-checking bench for shift_issue_queue
module tb_shift_issue_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_shamt;
    logic        in_oper;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  count;

    int checks = 0;
    int errors = 0;

    shift_issue_queue #(.OPERAND_WIDTH(16), .SHAMT_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt), .in_oper(in_oper),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] d, input logic [3:0] s, input logic o);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_oper  = o;
    endtask

    // One isolated request through an empty block with out_ready=1.
    task automatic send_one(input string tag, input logic [15:0] d, input logic [3:0] s,
                            input logic o, input logic [15:0] exp);
        drive(d, s, o);
        step();
        in_valid = 1'b0;
        chk({tag, "_count1"}, {14'd0, count}, 16'd1);
        chk({tag, "_vld0"}, {15'd0, out_valid}, 16'd0);
        step();
        chk({tag, "_vld1"}, {15'd0, out_valid}, 16'd1);
        chk({tag, "_data"}, out_data, exp);
        step();
        chk({tag, "_drain"}, {15'd0, out_valid}, 16'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        in_shamt  = 4'h0;
        in_oper   = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_count", {14'd0, count}, 16'd0);
        chk("rst_vld", {15'd0, out_valid}, 16'd0);
        chk("rst_data", out_data, 16'h0000);
        chk("rst_rdy", {15'd0, in_ready}, 16'd0);
        rst = 1'b0;
        step();
        chk("post_rst_rdy", {15'd0, in_ready}, 16'd1);

        out_ready = 1'b1;
        send_one("rot_8001_1", 16'h8001, 4'd1, 1'b0, 16'hC000);
        send_one("srl_f0f0_4", 16'hF0F0, 4'd4, 1'b1, 16'h0F0F);
        send_one("srl_8001_15", 16'h8001, 4'd15, 1'b1, 16'h0001);
        send_one("rot_1234_0", 16'h1234, 4'd0, 1'b0, 16'h1234);
        send_one("srl_1234_0", 16'h1234, 4'd0, 1'b1, 16'h1234);
        send_one("rot_8001_15", 16'h8001, 4'd15, 1'b0, 16'h0003);
        send_one("rot_1234_4", 16'h1234, 4'd4, 1'b0, 16'h4123);

        // Backpressure: A in result register, B and C queued, D stalled.
        out_ready = 1'b0;
        drive(16'h1111, 4'd0, 1'b0);
        step();
        drive(16'h2222, 4'd0, 1'b0);
        step();
        chk("bp_a_vld", {15'd0, out_valid}, 16'd1);
        chk("bp_a_data", out_data, 16'h1111);
        drive(16'h3333, 4'd0, 1'b0);
        step();
        chk("bp_full_count", {14'd0, count}, 16'd2);
        chk("bp_full_rdy", {15'd0, in_ready}, 16'd0);
        drive(16'h4444, 4'd0, 1'b0);
        step();
        chk("bp_stall_count", {14'd0, count}, 16'd2);
        chk("bp_stall_data", out_data, 16'h1111);
        step();
        chk("bp_stall2_data", out_data, 16'h1111);
        chk("bp_stall2_vld", {15'd0, out_valid}, 16'd1);
        out_ready = 1'b1;
        step();
        chk("bp_b_data", out_data, 16'h2222);
        chk("bp_b_count", {14'd0, count}, 16'd1);
        chk("bp_b_rdy", {15'd0, in_ready}, 16'd1);
        step();
        in_valid = 1'b0;
        chk("bp_c_data", out_data, 16'h3333);
        chk("bp_c_count", {14'd0, count}, 16'd1);
        step();
        chk("bp_d_data", out_data, 16'h4444);
        chk("bp_d_count", {14'd0, count}, 16'd0);
        step();
        chk("bp_drain", {15'd0, out_valid}, 16'd0);

        // Streaming: one result per cycle, each shifted back to 16'h0001.
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(16'h0001 << i, i[3:0], 1'b1);
            else in_valid = 1'b0;
            step();
            if (i >= 1 && i <= 8) begin
                chk($sformatf("stream_vld%0d", i), {15'd0, out_valid}, 16'd1);
                chk($sformatf("stream_data%0d", i), out_data, 16'h0001);
            end
            if (i == 9) chk("stream_end", {15'd0, out_valid}, 16'd0);
        end

        // Reset mid-flight with count=2 and out_valid=1.
        out_ready = 1'b0;
        drive(16'hAAAA, 4'd0, 1'b0);
        step();
        drive(16'hBBBB, 4'd0, 1'b0);
        step();
        drive(16'hCCCC, 4'd0, 1'b0);
        step();
        in_valid = 1'b0;
        chk("mid_count", {14'd0, count}, 16'd2);
        chk("mid_vld", {15'd0, out_valid}, 16'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_count", {14'd0, count}, 16'd0);
        chk("async_vld", {15'd0, out_valid}, 16'd0);
        chk("async_data", out_data, 16'h0000);
        chk("async_rdy", {15'd0, in_ready}, 16'd0);
        #1 rst = 1'b0;
        step();
        chk("rel_rdy", {15'd0, in_ready}, 16'd1);
        chk("rel_vld", {15'd0, out_valid}, 16'd0);
        out_ready = 1'b1;
        drive(16'hABCD, 4'd0, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        chk("rel_res_vld", {15'd0, out_valid}, 16'd1);
        chk("rel_res_data", out_data, 16'hABCD);
        step();
        chk("rel_once_vld", {15'd0, out_valid}, 16'd0);
        step();
        chk("rel_stale_vld", {15'd0, out_valid}, 16'd0);
        chk("rel_count", {14'd0, count}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
